regfile_multiport: RTL

- Parametrised successor to the RV32I 2-read/1-write register file.
- Configurable data width, depth and number of read ports.
- Optional write-to-read bypass.
- Hardware clear sequencer zeroes every register after reset or on request, signalling `busy` while it runs.
- Sits in the core's decode/writeback path; the pipeline stalls issue while `busy` is high.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_clear_seq.sv | 58 +++++
 rtl/regfile_multiport.sv | 64 ++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file and its clear sequencer.
package regfile_pkg;

    typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

    localparam int RF_XLEN_DEF     = 32;
    localparam int RF_NUM_REGS_DEF = 32;
    localparam int RF_NUM_READ_DEF = 2;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps registers 1..NUM_REGS-1 to zero after reset or on request,
// holding busy high for the whole sweep.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS       = RF_NUM_REGS_DEF,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int AW             = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear_req,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    rf_state_t     r_state;
    rf_state_t     w_next_state;
    logic [AW-1:0] r_clr_idx;
    logic [AW-1:0] w_next_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? RF_CLEAR : RF_IDLE;
            r_clr_idx <= AW'(1);
        end else begin
            r_state   <= w_next_state;
            r_clr_idx <= w_next_idx;
        end
    end

    // Index 0 is hardwired zero, so the sweep starts at 1 and ends on the last register.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_clr_idx;
        case (r_state)
            RF_IDLE: begin
                if (i_clear_req) begin
                    w_next_state = RF_CLEAR;
                    w_next_idx   = AW'(1);
                end
            end
            RF_CLEAR: begin
                w_next_idx = r_clr_idx + AW'(1);
                if (r_clr_idx == AW'(NUM_REGS - 1)) begin
                    w_next_state = RF_IDLE;
                end
            end
            default: w_next_state = RF_IDLE;
        endcase
    end

    assign o_busy     = (r_state == RF_CLEAR);
    assign o_clr_we   = (r_state == RF_CLEAR) && !reset;
    assign o_clr_addr = r_clr_idx;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-read-port register file with x0 hardwired to zero, optional
// write-to-read bypass and a hardware clear sweep that locks out access while busy.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter  int XLEN           = RF_XLEN_DEF,
    parameter  int NUM_REGS       = RF_NUM_REGS_DEF,
    parameter  int NUM_READ       = RF_NUM_READ_DEF,
    parameter  int BYPASS         = 1,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int AW             = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_write,
    input  logic [AW-1:0]            rd,
    input  logic [XLEN-1:0]          write_data,
    input  logic [NUM_READ*AW-1:0]   rs,
    output logic [NUM_READ*XLEN-1:0] read_data,
    input  logic                     clear_req,
    output logic                     busy
);

    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic            w_busy;
    logic            w_clr_we;
    logic [AW-1:0]   w_clr_addr;
    logic            w_wr_en;

    regfile_clear_seq #(
        .NUM_REGS       (NUM_REGS),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk         (clk),
        .reset       (reset),
        .i_clear_req (clear_req),
        .o_busy      (w_busy),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr)
    );

    assign busy    = w_busy;
    assign w_wr_en = reg_write && !w_busy && (rd != '0);

    // The sweep owns the write port while running; architectural writes are dropped, not queued.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_regs[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            r_regs[rd] <= write_data;
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_read
        logic [AW-1:0] w_rs;
        assign w_rs = rs[g*AW +: AW];
        assign read_data[g*XLEN +: XLEN] =
            w_busy                                         ? '0 :
            (w_rs == '0)                                   ? '0 :
            ((BYPASS != 0) && reg_write && (rd == w_rs))   ? write_data :
                                                             r_regs[w_rs];
    end

endmodule
